fir_mac_sched: RTL

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_mac_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fir_mac_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fir_mac_sched                                                   |
// | Brief    : FIR multiply-accumulate scheduler driving a fixed-latency FPALU. |
// |            Optional job counter enabled by macro FIR_SCHED_PERF_EN.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fir_mac_sched #(
  parameter int NTAP    = 8,
  parameter int ALU_LAT = 4,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] tap_addr,
  output logic          alu_issue,
  output logic          alu_add_muln,
  output logic          prod_we,
  output logic          acc_we,
  output logic          acc_clr,
  output logic [15:0]   perf_jobs
);

  localparam int            c_wait_w    = 4;
  localparam logic [3:0]    c_last_wait = c_wait_w'(ALU_LAT - 1);
  localparam logic [3:0]    c_wait_one  = 4'd1;
  localparam logic [AW-1:0] c_last_tap  = AW'(NTAP - 1);
  localparam logic [AW-1:0] c_tap_one   = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL_ISSUE = 3'd1,
    S_MUL_WAIT  = 3'd2,
    S_ADD_ISSUE = 3'd3,
    S_ADD_WAIT  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_tap;
  logic [AW-1:0] w_tap_nxt;
  logic [3:0]    r_wait;
  logic [3:0]    w_wait_nxt;
  logic          w_wait_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tap   <= w_tap_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  assign w_wait_last = (r_wait == c_last_wait);
  assign tap_addr    = r_tap;

  always_comb begin
    w_state_nxt  = r_state;
    w_tap_nxt    = r_tap;
    w_wait_nxt   = r_wait;
    busy         = 1'b1;
    done         = 1'b0;
    alu_issue    = 1'b0;
    alu_add_muln = 1'b1;
    prod_we      = 1'b0;
    acc_we       = 1'b0;
    acc_clr      = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        // rst_n term keeps acc_clr low while reset is held with start high
        if (start && !abort && rst_n) begin
          w_state_nxt = S_MUL_ISSUE;
          w_tap_nxt   = '0;
          acc_clr     = 1'b1;
        end
      end
      S_MUL_ISSUE: begin
        alu_issue    = 1'b1;
        alu_add_muln = 1'b0;
        w_wait_nxt   = '0;
        w_state_nxt  = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        alu_add_muln = 1'b0;
        if (w_wait_last) begin
          prod_we     = 1'b1;
          w_wait_nxt  = '0;
          w_state_nxt = S_ADD_ISSUE;
        end else begin
          w_wait_nxt = r_wait + c_wait_one;
        end
      end
      S_ADD_ISSUE: begin
        alu_issue   = 1'b1;
        w_wait_nxt  = '0;
        w_state_nxt = S_ADD_WAIT;
      end
      S_ADD_WAIT: begin
        if (w_wait_last) begin
          acc_we     = 1'b1;
          w_wait_nxt = '0;
          if (r_tap < c_last_tap) begin
            w_tap_nxt   = r_tap + c_tap_one;
            w_state_nxt = S_MUL_ISSUE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_wait_nxt = r_wait + c_wait_one;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // abort kills the job before any result write or completion is signalled
    if (r_state != S_IDLE && abort) begin
      w_state_nxt = S_IDLE;
      w_wait_nxt  = '0;
      w_tap_nxt   = r_tap;
      done        = 1'b0;
      prod_we     = 1'b0;
      acc_we      = 1'b0;
    end
  end

`ifdef FIR_SCHED_PERF_EN
  logic [15:0] r_perf_jobs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_jobs <= '0;
    end else if (done && (r_perf_jobs != 16'hFFFF)) begin
      r_perf_jobs <= r_perf_jobs + 16'd1;
    end
  end

  assign perf_jobs = r_perf_jobs;
`else
  assign perf_jobs = 16'h0000;
`endif

endmodule
`default_nettype wire
